// File: rtl/huffman_stream_decoder.sv
// rtl/huffman_stream_decoder.sv - buffered bit-serial Huffman tree walker with backpressured symbol output
module huffman_stream_decoder #(
    parameter int NUMCODES = 288,
    parameter int OUTWIDTH = 10,
    parameter int INWIDTH  = 8,
    parameter int MAXLEN   = 15,
    localparam int AW = $clog2(2 * NUMCODES),
    localparam int LW = $clog2(MAXLEN + 1),
    localparam int CW = $clog2(2 * INWIDTH + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                istart,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INWIDTH-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUTWIDTH-1:0] out_code,
    output logic [LW-1:0]       out_len,
    output logic                err,
    output logic [CW-1:0]       bit_cnt,
    output logic [AW-1:0]       rdaddr,
    input  logic [OUTWIDTH-1:0] rddata
);
    localparam int NW = AW - 1;
    localparam int BW = 2 * INWIDTH;
    localparam logic [OUTWIDTH-1:0] NC   = OUTWIDTH'(NUMCODES);
    localparam logic [LW-1:0]       MAXD = LW'(MAXLEN);
    localparam logic [CW-1:0]       INW  = CW'(INWIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_ERR
    } state_t;

    state_t        state;
    logic [BW-1:0] bits;
    logic [NW-1:0] node;
    logic [LW-1:0] depth;
    logic [AW-1:0] addr_q;

    logic          stall;
    logic          leaf;
    logic          eval;
    logic          eval_err;
    logic          issue;
    logic          accept;
    logic [NW-1:0] node_cur;
    logic [LW-1:0] depth_cur;
    logic [BW-1:0] bits_left;
    logic [BW-1:0] bits_next;
    logic [CW-1:0] cnt_left;
    logic [CW-1:0] cnt_next;

    // A word is only taken when it is guaranteed to fit above the buffered bits.
    assign in_ready = (bit_cnt <= INW) && !err && !istart;
    assign accept   = in_valid && in_ready;

    // Walk decision: evaluate the returned entry, pick the next node and drive the table address.
    always_comb begin
        stall     = out_valid && !out_ready;
        leaf      = rddata < NC;
        eval      = (state == S_WALK) && !stall;
        eval_err  = eval && !leaf && (depth == MAXD);
        node_cur  = node;
        depth_cur = depth;
        if (state == S_WALK) begin
            node_cur  = leaf ? '0 : NW'(rddata - NC);
            depth_cur = leaf ? '0 : depth;
        end
        issue = (state != S_ERR) && !istart && !stall && !eval_err && (bit_cnt != '0);
        // Holding the last address while idle or stalled keeps rddata valid for re-evaluation.
        rdaddr = issue ? {node_cur, bits[0]} : addr_q;
    end

    // Buffer update: drop the consumed bit, then append an accepted word above what remains.
    always_comb begin
        bits_left = issue ? (bits >> 1) : bits;
        cnt_left  = bit_cnt - CW'(issue);
        bits_next = bits_left;
        cnt_next  = cnt_left;
        if (accept) begin
            bits_next = bits_left | (BW'(in_data) << cnt_left);
            cnt_next  = cnt_left + INW;
        end
    end

    // Bit buffer registers; restart flushes every buffered bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bits    <= '0;
            bit_cnt <= '0;
        end else if (istart) begin
            bits    <= '0;
            bit_cnt <= '0;
        end else begin
            bits    <= bits_next;
            bit_cnt <= cnt_next;
        end
    end

    // Walker state, symbol output register and sticky error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            node      <= '0;
            depth     <= '0;
            addr_q    <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_len   <= '0;
            err       <= 1'b0;
        end else if (istart) begin
            state     <= S_IDLE;
            node      <= '0;
            depth     <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A leaf completing in the handshake cycle reloads the register without a gap.
            if (eval && leaf) begin
                out_valid <= 1'b1;
                out_code  <= rddata;
                out_len   <= depth;
            end
            if (eval_err) begin
                state <= S_ERR;
                err   <= 1'b1;
                node  <= '0;
                depth <= '0;
            end else if (issue) begin
                addr_q <= rdaddr;
                node   <= node_cur;
                depth  <= depth_cur + LW'(1);
                state  <= S_WALK;
            end else if (eval) begin
                // Starved mid-code: park on the current node so the walk resumes there.
                node  <= node_cur;
                depth <= depth_cur;
                state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_huffman_stream_decoder.sv
// tb/tb_huffman_stream_decoder.sv - scoreboard bench for huffman_stream_decoder with a prefix-code reference model
module tb_huffman_stream_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, istart, in_valid, in_ready, out_valid, out_ready, err;
    logic [7:0] in_data;
    logic [2:0] out_code, rddata, rdaddr;
    logic [1:0] out_len;
    logic [4:0] bit_cnt;

    logic       e_istart, e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_err;
    logic [7:0] e_in_data;
    logic [2:0] e_out_code, e_rddata, e_rdaddr;
    logic [1:0] e_out_len;
    logic [4:0] e_bit_cnt;

    huffman_stream_decoder #(.NUMCODES(4), .OUTWIDTH(3), .INWIDTH(8), .MAXLEN(3)) dut (
        .clk(clk), .rstn(rstn), .istart(istart), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_len(out_len), .err(err), .bit_cnt(bit_cnt), .rdaddr(rdaddr), .rddata(rddata)
    );

    huffman_stream_decoder #(.NUMCODES(4), .OUTWIDTH(3), .INWIDTH(8), .MAXLEN(2)) dut_err (
        .clk(clk), .rstn(rstn), .istart(e_istart), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .in_data(e_in_data), .out_valid(e_out_valid), .out_ready(e_out_ready), .out_code(e_out_code),
        .out_len(e_out_len), .err(e_err), .bit_cnt(e_bit_cnt), .rdaddr(e_rdaddr), .rddata(e_rddata)
    );

    // Tree table for A=0, B=10, C=110, D=111 behind a one-cycle synchronous read
    logic [2:0] mem [0:7];
    initial begin
        mem[0] = 3'd0; mem[1] = 3'd5; mem[2] = 3'd1; mem[3] = 3'd6;
        mem[4] = 3'd2; mem[5] = 3'd3; mem[6] = 3'd0; mem[7] = 3'd0;
    end
    always @(posedge clk) rddata   <= mem[rdaddr];
    always @(posedge clk) e_rddata <= mem[e_rdaddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int code;
        int len;
    } sym_t;

    sym_t exp_q[$];
    bit   bq[$];
    int   hs_cyc[$];
    int   first_valid_cyc = -1;
    int   compared = 0;
    int   mismatched = 0;
    bit   e_saw_valid = 0;
    bit   done = 0;
    int   acc0, dummy;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference decoder: a code is k ones followed by a zero (symbol k, length k+1), or three ones (symbol 3)
    task automatic model_decode();
        int n;
        while (bq.size() > 0) begin
            n = 0;
            while (n < bq.size() && n < 3 && bq[n] == 1'b1) n++;
            if (n == 3) begin
                exp_q.push_back('{3, 3});
                repeat (3) void'(bq.pop_front());
            end else if (n < bq.size()) begin
                exp_q.push_back('{n, n + 1});
                repeat (n + 1) void'(bq.pop_front());
            end else begin
                break;
            end
        end
    endtask

    task automatic model_push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) bq.push_back(w[i]);
        model_decode();
    endtask

    // Called at a falling edge; returns at a falling edge after the beat is accepted
    task automatic send_word(input logic [7:0] w, output int acc);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        #1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        acc = cyc;
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL in_ready_timeout: in_ready %0b required 1", in_ready);
        end else begin
            model_push_word(w);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_timeout: %0d symbols outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Returns at falling edge + 1 with out_valid seen high
    task automatic wait_valid();
        int n;
        n = 0;
        #1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_out_valid", out_valid, 1);
    endtask

    task automatic do_istart();
        @(negedge clk);
        istart = 1'b1;
        exp_q.delete();
        bq.delete();
        @(negedge clk);
        istart = 1'b0;
    endtask

    // Monitor: pop the scoreboard on every output handshake
    initial begin
        sym_t s;
        forever begin
            @(negedge clk);
            #1;
            if (e_out_valid) e_saw_valid = 1'b1;
            if (rstn && !istart && out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rstn && !istart && out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_symbol: got code %0d len %0d, scoreboard empty", out_code, out_len);
                end else begin
                    s = exp_q.pop_front();
                    check("sym_code", int'(out_code), s.code);
                    check("sym_len", int'(out_len), s.len);
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; istart = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        e_istart = 1'b0; e_in_valid = 1'b0; e_in_data = 8'h00; e_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_code", out_code, 0);
        check("rst_out_len", out_len, 0);
        check("rst_err", err, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_rdaddr", rdaddr, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Depth overrun on the MAXLEN=2 instance
        @(negedge clk);
        e_in_valid = 1'b1;
        e_in_data  = 8'hFF;
        #1;
        check("err_in_ready_pre", e_in_ready, 1);
        @(negedge clk);
        e_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("err_before_second_eval", e_err, 0);
        @(negedge clk);
        #1;
        check("err_after_second_eval", e_err, 1);
        check("err_in_ready", e_in_ready, 0);
        check("err_bit_cnt", e_bit_cnt, 6);
        repeat (4) @(negedge clk);
        #1;
        check("err_sticky", e_err, 1);
        check("err_no_out_valid", e_saw_valid, 0);
        @(negedge clk);
        e_istart = 1'b1;
        @(negedge clk);
        e_istart = 1'b0;
        #1;
        check("err_clr_err", e_err, 0);
        check("err_clr_bit_cnt", e_bit_cnt, 0);
        check("err_clr_in_ready", e_in_ready, 1);

        // Basic stream with latency and spacing
        @(negedge clk);
        out_ready = 1'b1;
        hs_cyc.delete();
        first_valid_cyc = -1;
        send_word(8'hDA, acc0);
        send_word(8'h01, dummy);
        wait_drain();
        check("first_valid_latency", first_valid_cyc - acc0, 3);
        check("basic_hs_count_ge4", int'(hs_cyc.size() >= 4), 1);
        if (hs_cyc.size() >= 4) begin
            check("gap_B", hs_cyc[1] - hs_cyc[0], 2);
            check("gap_C", hs_cyc[2] - hs_cyc[1], 3);
            check("gap_D", hs_cyc[3] - hs_cyc[2], 3);
        end
        check("basic_bit_cnt_end", bit_cnt, 0);

        // Backpressure: symbol A held, read address and buffer frozen
        do_istart();
        out_ready = 1'b0;
        send_word(8'hDA, dummy);
        send_word(8'h01, dummy);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_out_code", out_code, 0);
            check("stall_rdaddr", rdaddr, 1);
            check("stall_bit_cnt", bit_cnt, 14);
            @(negedge clk);
            if (k < 4) #1;
        end
        out_ready = 1'b1;
        wait_drain();

        // Starvation: the walk parks mid-code and resumes across the gap
        do_istart();
        send_word(8'h02, dummy);
        repeat (20) @(negedge clk);
        send_word(8'h80, dummy);
        repeat (20) @(negedge clk);
        #1;
        check("starve_bit_cnt", bit_cnt, 0);
        check("starve_pending", exp_q.size(), 0);
        @(negedge clk);
        send_word(8'hFF, dummy);
        wait_drain();
        check("starve_bit_cnt_end", bit_cnt, 0);

        // Collision: restart with a beat and a pending symbol
        do_istart();
        out_ready = 1'b0;
        send_word(8'hDA, dummy);
        wait_valid();
        @(negedge clk);
        istart = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        exp_q.delete();
        bq.delete();
        #1;
        check("coll_in_ready", in_ready, 0);
        @(negedge clk);
        istart = 1'b0;
        in_valid = 1'b0;
        #1;
        check("coll_out_valid", out_valid, 0);
        check("coll_bit_cnt", bit_cnt, 0);
        check("coll_err", err, 0);
        @(negedge clk);
        out_ready = 1'b1;
        send_word(8'hDA, dummy);
        wait_drain();

        // Randomized segments with random backpressure and input gaps
        for (int seg = 0; seg < 3; seg++) begin
            do_istart();
            done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 30; i++) begin
                        send_word(8'($urandom), dummy);
                        repeat ($urandom_range(0, 10)) @(negedge clk);
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(negedge clk);
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            join
            out_ready = 1'b1;
            wait_drain();
            check("rand_bit_cnt_le16", int'(bit_cnt <= 5'd16), 1);
        end

        // Asynchronous reset mid-walk
        do_istart();
        out_ready = 1'b0;
        send_word(8'hDA, dummy);
        send_word(8'h01, dummy);
        wait_valid();
        #2;
        rstn = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_code", out_code, 0);
        check("arst_out_len", out_len, 0);
        check("arst_err", err, 0);
        check("arst_bit_cnt", bit_cnt, 0);
        check("arst_rdaddr", rdaddr, 0);
        check("arst_in_ready", in_ready, 1);
        exp_q.delete();
        bq.delete();
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send_word(8'hDA, dummy);
        send_word(8'h01, dummy);
        wait_drain();
        check("final_bit_cnt", bit_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
